// File: rtl/ddr3_axi_arb.sv
// ddr3_axi_arb
// Two-master AXI4 arbiter in front of the single ddr3_axi slave port.
// Write and read directions are arbitrated independently, each with one
// transaction in flight from address handshake through its final response.
// Bursts and IDs pass through unchanged.
//
// Ports
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   inport_*_i / _o     : per-master AXI channels, master m in slice m
//   outport_*_o / _i    : single AXI master port toward ddr3_axi
//
// Write FSM
//   state  | meaning
//   W_IDLE | no write granted, arbitrating AW requests
//   W_ADDR | AW of wgnt routed downstream
//   W_DATA | W beats of wgnt routed until wlast handshake
//   W_RESP | B routed back to wgnt
// Read FSM
//   state  | meaning
//   R_IDLE | no read granted, arbitrating AR requests
//   R_ADDR | AR of rgnt routed downstream
//   R_DATA | R beats routed to rgnt until rlast handshake
module ddr3_axi_arb #(
   parameter bit FAIR_RR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  inport_awvalid_i,
   input  logic [63:0] inport_awaddr_i,
   input  logic [7:0]  inport_awid_i,
   input  logic [15:0] inport_awlen_i,
   input  logic [3:0]  inport_awburst_i,
   input  logic [1:0]  inport_wvalid_i,
   input  logic [63:0] inport_wdata_i,
   input  logic [7:0]  inport_wstrb_i,
   input  logic [1:0]  inport_wlast_i,
   input  logic [1:0]  inport_bready_i,
   input  logic [1:0]  inport_arvalid_i,
   input  logic [63:0] inport_araddr_i,
   input  logic [7:0]  inport_arid_i,
   input  logic [15:0] inport_arlen_i,
   input  logic [3:0]  inport_arburst_i,
   input  logic [1:0]  inport_rready_i,
   output logic [1:0]  inport_awready_o,
   output logic [1:0]  inport_wready_o,
   output logic [1:0]  inport_arready_o,
   output logic [1:0]  inport_bvalid_o,
   output logic [3:0]  inport_bresp_o,
   output logic [7:0]  inport_bid_o,
   output logic [1:0]  inport_rvalid_o,
   output logic [63:0] inport_rdata_o,
   output logic [3:0]  inport_rresp_o,
   output logic [7:0]  inport_rid_o,
   output logic [1:0]  inport_rlast_o,
   output logic        outport_awvalid_o,
   output logic [31:0] outport_awaddr_o,
   output logic [3:0]  outport_awid_o,
   output logic [7:0]  outport_awlen_o,
   output logic [1:0]  outport_awburst_o,
   output logic        outport_wvalid_o,
   output logic [31:0] outport_wdata_o,
   output logic [3:0]  outport_wstrb_o,
   output logic        outport_wlast_o,
   output logic        outport_bready_o,
   output logic        outport_arvalid_o,
   output logic [31:0] outport_araddr_o,
   output logic [3:0]  outport_arid_o,
   output logic [7:0]  outport_arlen_o,
   output logic [1:0]  outport_arburst_o,
   output logic        outport_rready_o,
   input  logic        outport_awready_i,
   input  logic        outport_wready_i,
   input  logic        outport_bvalid_i,
   input  logic [1:0]  outport_bresp_i,
   input  logic [3:0]  outport_bid_i,
   input  logic        outport_arready_i,
   input  logic        outport_rvalid_i,
   input  logic [31:0] outport_rdata_i,
   input  logic [1:0]  outport_rresp_i,
   input  logic [3:0]  outport_rid_i,
   input  logic        outport_rlast_i
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t wstate;
   rstate_t rstate;
   logic    wgnt, rgnt;
   logic    wptr, rptr;
   logic    wpick, rpick;
   // registered per-phase route enables, decoded alongside the state
   logic    aw_en, w_en, b_en, ar_en, r_en;

   // Single requester always wins; with both requesting, round-robin
   // prefers the master that did not win last time.
   always_comb begin
      wpick = 1'b0;
      rpick = 1'b0;
      if (!FAIR_RR) begin
         wpick = ~inport_awvalid_i[0];
         rpick = ~inport_arvalid_i[0];
      end else begin
         wpick = (&inport_awvalid_i) ? ~wptr : inport_awvalid_i[1];
         rpick = (&inport_arvalid_i) ? ~rptr : inport_arvalid_i[1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wstate <= W_IDLE;
         wgnt   <= 1'b0;
         wptr   <= 1'b1;
         aw_en  <= 1'b0;
         w_en   <= 1'b0;
         b_en   <= 1'b0;
      end else begin
         case (wstate)
            W_IDLE: if (|inport_awvalid_i) begin
               wgnt   <= wpick;
               wptr   <= wpick;
               aw_en  <= 1'b1;
               wstate <= W_ADDR;
            end
            W_ADDR: if (outport_awvalid_o && outport_awready_i) begin
               aw_en  <= 1'b0;
               w_en   <= 1'b1;
               wstate <= W_DATA;
            end
            W_DATA: if (outport_wvalid_o && outport_wready_i && outport_wlast_o) begin
               w_en   <= 1'b0;
               b_en   <= 1'b1;
               wstate <= W_RESP;
            end
            W_RESP: if (outport_bvalid_i && outport_bready_o) begin
               b_en   <= 1'b0;
               wstate <= W_IDLE;
            end
            default: begin
               aw_en  <= 1'b0;
               w_en   <= 1'b0;
               b_en   <= 1'b0;
               wstate <= W_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rstate <= R_IDLE;
         rgnt   <= 1'b0;
         rptr   <= 1'b1;
         ar_en  <= 1'b0;
         r_en   <= 1'b0;
      end else begin
         case (rstate)
            R_IDLE: if (|inport_arvalid_i) begin
               rgnt   <= rpick;
               rptr   <= rpick;
               ar_en  <= 1'b1;
               rstate <= R_ADDR;
            end
            R_ADDR: if (outport_arvalid_o && outport_arready_i) begin
               ar_en  <= 1'b0;
               r_en   <= 1'b1;
               rstate <= R_DATA;
            end
            R_DATA: if (outport_rvalid_i && outport_rready_o && outport_rlast_i) begin
               r_en   <= 1'b0;
               rstate <= R_IDLE;
            end
            default: begin
               ar_en  <= 1'b0;
               r_en   <= 1'b0;
               rstate <= R_IDLE;
            end
         endcase
      end
   end

   // Downstream payload always comes from the granted slice.
   assign outport_awvalid_o = aw_en & inport_awvalid_i[wgnt];
   assign outport_awaddr_o  = wgnt ? inport_awaddr_i[63:32] : inport_awaddr_i[31:0];
   assign outport_awid_o    = wgnt ? inport_awid_i[7:4]     : inport_awid_i[3:0];
   assign outport_awlen_o   = wgnt ? inport_awlen_i[15:8]   : inport_awlen_i[7:0];
   assign outport_awburst_o = wgnt ? inport_awburst_i[3:2]  : inport_awburst_i[1:0];
   assign outport_wvalid_o  = w_en & inport_wvalid_i[wgnt];
   assign outport_wdata_o   = wgnt ? inport_wdata_i[63:32]  : inport_wdata_i[31:0];
   assign outport_wstrb_o   = wgnt ? inport_wstrb_i[7:4]    : inport_wstrb_i[3:0];
   assign outport_wlast_o   = inport_wlast_i[wgnt];
   assign outport_bready_o  = b_en & inport_bready_i[wgnt];

   assign outport_arvalid_o = ar_en & inport_arvalid_i[rgnt];
   assign outport_araddr_o  = rgnt ? inport_araddr_i[63:32] : inport_araddr_i[31:0];
   assign outport_arid_o    = rgnt ? inport_arid_i[7:4]     : inport_arid_i[3:0];
   assign outport_arlen_o   = rgnt ? inport_arlen_i[15:8]   : inport_arlen_i[7:0];
   assign outport_arburst_o = rgnt ? inport_arburst_i[3:2]  : inport_arburst_i[1:0];
   assign outport_rready_o  = r_en & inport_rready_i[rgnt];

   // Upstream handshakes reach only the granted master; payloads broadcast.
   assign inport_awready_o = {wgnt, ~wgnt} & {2{aw_en & outport_awready_i}};
   assign inport_wready_o  = {wgnt, ~wgnt} & {2{w_en  & outport_wready_i}};
   assign inport_bvalid_o  = {wgnt, ~wgnt} & {2{b_en  & outport_bvalid_i}};
   assign inport_bresp_o   = {2{outport_bresp_i}};
   assign inport_bid_o     = {2{outport_bid_i}};

   assign inport_arready_o = {rgnt, ~rgnt} & {2{ar_en & outport_arready_i}};
   assign inport_rvalid_o  = {rgnt, ~rgnt} & {2{r_en  & outport_rvalid_i}};
   assign inport_rdata_o   = {2{outport_rdata_i}};
   assign inport_rresp_o   = {2{outport_rresp_i}};
   assign inport_rid_o     = {2{outport_rid_i}};
   assign inport_rlast_o   = {2{outport_rlast_i}};

endmodule
